// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: key-length decode, Rcon arithmetic, FSM states.
package aes_pkg;

  typedef enum logic [1:0] {
    KL_128 = 2'b00,
    KL_192 = 2'b01,
    KL_256 = 2'b10,
    KL_BAD = 2'b11
  } key_len_e;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } state_e;

  typedef struct packed {
    logic [3:0] nk;
    logic [3:0] nr;
    logic       legal;
  } key_cfg_t;

  localparam logic [7:0] RCON_INIT = 8'h01;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Nk / Nr for a key_len code; the illegal code reports legal=0.
  function automatic key_cfg_t key_cfg(input logic [1:0] kl);
    key_cfg_t c;
    case (key_len_e'(kl))
      KL_128:  c = '{nk: 4'd4, nr: 4'd10, legal: 1'b1};
      KL_192:  c = '{nk: 4'd6, nr: 4'd12, legal: 1'b1};
      KL_256:  c = '{nk: 4'd8, nr: 4'd14, legal: 1'b1};
      default: c = '{nk: 4'd0, nr: 4'd0,  legal: 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box (8-bit lookup).
module aes_sbox (
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);

  // Entry 0 sits in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // MSB of entry x is bit 2047-8x = {~x, 3'b111}.
  assign byte_o = SBOX_TABLE[{~byte_i, 3'b111} -: 8];

endmodule

// File: rtl/aes_key_expand_seq.sv
// Sequential AES-128/192/256 key scheduler: one schedule word per clock into a
// round-key register file, with a registered 128-bit round-key read port.
module aes_key_expand_seq
  import aes_pkg::*;
#(
  parameter int MAX_NK    = 8,
  parameter int MAX_WORDS = 4 * (MAX_NK + 7)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            key_len,
  input  logic [32*MAX_NK-1:0]  key,
  input  logic                  zeroize,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [3:0]            nr,
  output logic                  rk_ready,
  input  logic [3:0]            rk_rd_round,
  output logic [127:0]          rk_rd_data
);

  localparam int IW = $clog2(MAX_WORDS);

  state_e        state_q;
  logic [31:0]   w_q [MAX_WORDS];
  logic [IW-1:0] i_q;
  logic [IW-1:0] end_q;
  logic [3:0]    phase_q;
  logic [3:0]    nk_q;
  logic [3:0]    nr_lat_q;
  logic [3:0]    nr_q;
  logic [7:0]    rcon_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;
  logic          rk_ready_q;
  logic [127:0]  rd_data_q;

  key_cfg_t      cfg;
  logic          start_ok;
  logic [31:0]   key_word [MAX_NK];
  logic [IW-1:0] prev_idx;
  logic [IW-1:0] back_idx;
  logic [31:0]   temp_raw;
  logic [31:0]   sub_in;
  logic [31:0]   sub_out;
  logic [31:0]   temp;
  logic [31:0]   word_d;
  logic [127:0]  rd_data_d;

  // Decode the requested key length and split the right-aligned key into words.
  always_comb begin
    cfg      = key_cfg(key_len);
    start_ok = cfg.legal && (cfg.nk <= 4'(MAX_NK));
    for (int unsigned j = 0; j < MAX_NK; j++) begin
      key_word[j] = '0;
      if (4'(j) < cfg.nk) begin
        key_word[j] = 32'(key >> (32 * (int'(cfg.nk) - 1 - int'(j))));
      end
    end
  end

  // Next schedule word w[i] from w[i-1] and w[i-Nk] through the shared SubWord.
  always_comb begin
    prev_idx = i_q - 1'b1;
    back_idx = i_q - IW'(nk_q);
    temp_raw = w_q[prev_idx];
    sub_in   = (phase_q == 4'd0) ? {temp_raw[23:0], temp_raw[31:24]} : temp_raw;
    if (phase_q == 4'd0) begin
      temp = sub_out ^ {rcon_q, 24'h0};
    end else if (nk_q == 4'd8 && phase_q == 4'd4) begin
      temp = sub_out;
    end else begin
      temp = temp_raw;
    end
    word_d = w_q[back_idx] ^ temp;
  end

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .byte_i (sub_in[8*b +: 8]),
      .byte_o (sub_out[8*b +: 8])
    );
  end

  // Gather the four words of the requested round; slots past the file read as 0.
  always_comb begin
    rd_data_d = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (7'({rk_rd_round, 2'(k)}) < 7'(MAX_WORDS)) begin
        rd_data_d[127-32*k -: 32] = w_q[IW'({rk_rd_round, 2'(k)})];
      end
    end
  end

  // Control FSM, schedule register file and registered read port.
  // EXPAND spends one cycle past the last write (i == 4*(Nr+1)) so that the
  // done pulse lands 4*(Nr+1)-Nk+1 edges after the accepting edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      for (int unsigned k = 0; k < MAX_WORDS; k++) w_q[k] <= '0;
      i_q        <= '0;
      end_q      <= '0;
      phase_q    <= '0;
      nk_q       <= '0;
      nr_lat_q   <= '0;
      nr_q       <= '0;
      rcon_q     <= RCON_INIT;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rk_ready_q <= 1'b0;
      rd_data_q  <= '0;
    end else if (zeroize) begin
      state_q    <= IDLE;
      for (int unsigned k = 0; k < MAX_WORDS; k++) w_q[k] <= '0;
      i_q        <= '0;
      end_q      <= '0;
      phase_q    <= '0;
      nk_q       <= '0;
      nr_lat_q   <= '0;
      nr_q       <= '0;
      rcon_q     <= RCON_INIT;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rk_ready_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_data_q <= rd_data_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (start_ok) begin
              for (int unsigned j = 0; j < MAX_NK; j++) begin
                if (4'(j) < cfg.nk) w_q[j] <= key_word[j];
              end
              nk_q       <= cfg.nk;
              nr_lat_q   <= cfg.nr;
              i_q        <= IW'(cfg.nk);
              end_q      <= IW'({cfg.nr + 4'd1, 2'b00});
              phase_q    <= '0;
              rcon_q     <= RCON_INIT;
              busy_q     <= 1'b1;
              rk_ready_q <= 1'b0;
              state_q    <= EXPAND;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        EXPAND: begin
          if (i_q == end_q) begin
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            rk_ready_q <= 1'b1;
            nr_q       <= nr_lat_q;
            state_q    <= DONE;
          end else begin
            w_q[i_q] <= word_d;
            i_q      <= i_q + 1'b1;
            phase_q  <= (phase_q == nk_q - 4'd1) ? 4'd0 : phase_q + 4'd1;
            if (phase_q == 4'd0) rcon_q <= xtime(rcon_q);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign nr         = nr_q;
  assign rk_ready   = rk_ready_q;
  assign rk_rd_data = rd_data_q;

endmodule
